// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full_adder cell processes the operand
// pair LSB first, one bit per clock, with valid/ready handshakes on both sides.

module full_adder (
  input  logic ain,
  input  logic bin,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = ain ^ bin ^ cin;
  assign cout = (ain & bin) | (ain & cin) | (bin & cin);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_c;
  logic             accept, last;

  full_adder u_fa (
    .ain  (a_sh[0]),
    .bin  (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nx = fa_s;
    end else begin : g_wn
      assign res_nx = {fa_s, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Results are copied into dedicated output registers on the final bit so they
  // survive the next accept (which reloads carry) until the following DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res   <= res_nx;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nx;
        cout <= fa_c;
        // carry here is the carry into the MSB
        ovf  <= carry ^ fa_c;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table plus
// hand-written backpressure, ignored-input and mid-operation reset sequences.

module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         exp;
  } vec_t;

  res_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    logic [W:0] t;
    res_t r;
    t = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + {{W{1'b0}}, ms};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = ms ? ((ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]))
                : ((ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]));
    return r;
  endfunction

  // Drive an operand pair and wait for acceptance; returns one cycle after the accept edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input res_t exp, input bit keep_valid);
    int unsigned n = 0;
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready never rose, expected 1");
    end
    sb.push_back(exp);
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall for 'hold' cycles, then handshake and compare.
  task automatic recv(input int unsigned hold);
    int unsigned n = 0;
    logic [W-1:0] s0;
    res_t e;
    while (!out_valid && n < 64) begin
      check("run_in_ready", in_ready, 0);
      tick(); n++;
    end
    check("latency", n, W);
    if (!out_valid) return;
    s0 = sum;
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_sum", sum, s0);
      check("hold_in_ready", in_ready, 0);
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: result with no expected entry, expected queued entry");
      return;
    end
    e = sb.pop_front();
    check("sum", sum, e.sum);
    check("cout", cout, e.cout);
    check("ovf", ovf, e.ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_sum_kept", sum, e.sum);
  endtask

  initial begin
    vec_t vecs[8];
    logic [W-1:0] ra, rb;
    logic rs;
    bit saw;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, exp: '{sum: 8'h96, cout: 1'b0, ovf: 1'b1}};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}};
    vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, exp: '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0}};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, exp: '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1}};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, exp: '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}};
    vecs[6] = '{a: 8'h80, b: 8'h80, sub: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b1}};
    vecs[7] = '{a: 8'h7F, b: 8'hFF, sub: 1'b1, exp: '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, 1'b0);
      recv(0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, model(ra, rb, rs), 1'b0);
      recv(i == 0 ? 2 : 0);
    end

    // Backpressure: result held for 5 stalled cycles
    send(8'h5A, 8'h3C, 1'b0, model(8'h5A, 8'h3C, 1'b0), 1'b0);
    recv(5);

    // in_valid held with new operands during RUN/DONE is ignored until IDLE
    send(8'h11, 8'h22, 1'b0, model(8'h11, 8'h22, 1'b0), 1'b1);
    a = 8'hC3; b = 8'h44; sub = 1'b1;
    recv(1);
    sb.push_back(model(8'hC3, 8'h44, 1'b1));
    tick();
    check("reaccept_busy", busy, 1);
    check("reaccept_in_ready", in_ready, 0);
    in_valid = 1'b0;
    recv(0);

    // Asynchronous reset during the third RUN cycle
    send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0), 1'b0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_ovf", ovf, 0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    saw = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      saw |= out_valid;
    end
    check("no_valid_after_reset", saw, 0);
    send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0), 1'b0);
    recv(0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
